popcount_frame_accum: RTL and testbench

POPCOUNT_FRAME_ACCUM -- requirements
Module: popcount_frame_accum

---
 rtl/popcount_pkg.sv | 11 +
 rtl/popcount_8b.sv | 14 +
 rtl/popcount_frame_accum.sv | 96 +++++++++
 tb/tb_popcount_frame_accum.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types and widths for the frame popcount accumulator.
package popcount_pkg;

  localparam int unsigned SUM_W = 12;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/popcount_8b.sv
// Combinational set-bit count of one byte (result 0..8).
module popcount_8b (
  input  logic [7:0] in_,
  output logic [3:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + 4'(in_[i]);
    end
  end

endmodule

// File: rtl/popcount_frame_accum.sv
// Accumulates set bits over p_nbytes-byte frames and hands the total downstream.
// Optional synchronous frame abort port `clear` when POPCOUNT_FRAME_ACCUM_CLEAR_EN is defined.
module popcount_frame_accum
  import popcount_pkg::*;
#(
  parameter int unsigned p_nbytes = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [7:0]       in_,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [SUM_W-1:0] out
`ifdef POPCOUNT_FRAME_ACCUM_CLEAR_EN
  ,
  input  logic             clear
`endif
);

  localparam logic [7:0] LAST = 8'(p_nbytes - 1);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             in_rdy_q, in_rdy_d;
  logic             out_val_q, out_val_d;
  logic [3:0]       byte_ones;
  logic             abort;

  popcount_8b u_popcount_8b (
    .in_ (in_),
    .cnt (byte_ones)
  );

`ifdef POPCOUNT_FRAME_ACCUM_CLEAR_EN
  assign abort = clear;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACCUM: begin
        if (in_val && in_rdy_q) begin
          sum_d = sum_q + SUM_W'(byte_ones);
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DONE: begin
        if (out_rdy && out_val_q) begin
          state_d = ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
    if (abort) begin
      state_d = ACCUM;
      sum_d   = '0;
      cnt_d   = '0;
    end
    // Handshake outputs are registered copies of the next state, so they stay Moore.
    in_rdy_d  = (state_d == ACCUM);
    out_val_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      sum_q     <= '0;
      cnt_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_val = out_val_q;
  assign out     = sum_q;

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Self-checking bench: directed frames plus random traffic on a 4-byte and a 1-byte instance.
module tb_popcount_frame_accum;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] clr = 2'b00;
  logic [1:0] in_val = 2'b00;
  logic [1:0] out_rdy = 2'b00;
  logic [1:0] in_rdy, out_val;
  logic [7:0] in_b [2];
  logic [11:0] out_w [2];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference: per instance, frame length, bytes taken so far, their set-bit total, pending flag.
  int unsigned m_len  [2] = '{4, 1};
  int unsigned m_taken[2];
  int unsigned m_sum  [2];
  bit          m_pend [2];

  always #5 clk = ~clk;

  popcount_frame_accum #(.p_nbytes(4)) dut4 (
    .clk     (clk),
    .reset   (rst[0]),
    .in_val  (in_val[0]),
    .in_rdy  (in_rdy[0]),
    .in_     (in_b[0]),
    .out_val (out_val[0]),
    .out_rdy (out_rdy[0]),
    .out     (out_w[0])
`ifdef POPCOUNT_FRAME_ACCUM_CLEAR_EN
    ,
    .clear   (clr[0])
`endif
  );

  popcount_frame_accum #(.p_nbytes(1)) dut1 (
    .clk     (clk),
    .reset   (rst[1]),
    .in_val  (in_val[1]),
    .in_rdy  (in_rdy[1]),
    .in_     (in_b[1]),
    .out_val (out_val[1]),
    .out_rdy (out_rdy[1]),
    .out     (out_w[1])
`ifdef POPCOUNT_FRAME_ACCUM_CLEAR_EN
    ,
    .clear   (clr[1])
`endif
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    m_taken[k] = 0;
    m_sum[k]   = 0;
    m_pend[k]  = 1'b0;
  endtask

  task automatic model_edge(input int k);
    if (rst[k] || clr[k]) begin
      model_clear(k);
    end else if (m_pend[k]) begin
      if (out_rdy[k]) model_clear(k);
    end else if (in_val[k]) begin
      m_taken[k]++;
      m_sum[k] += $countones(in_b[k]);
      if (m_taken[k] == m_len[k]) m_pend[k] = 1'b1;
    end
  endtask

  task automatic compare(input int d);
    check("in_rdy", int'(in_rdy[d]), int'(!m_pend[d]));
    check("out_val", int'(out_val[d]), int'(m_pend[d]));
    if (m_pend[d] || m_taken[d] == 0) check("out", out_w[d], m_sum[d]);
  endtask

  // Called at a falling edge: check dut d, drive one cycle of inputs, advance the model.
  task automatic cyc(input int d, input bit v, input logic [7:0] b, input bit o,
                     input bit r, input bit c);
    compare(d);
    in_val  = 2'b00;
    out_rdy = 2'b00;
    rst     = 2'b00;
    clr     = 2'b00;
    in_val[d]  = v;
    in_b[d]    = b;
    out_rdy[d] = o;
    rst[d]     = r;
`ifdef POPCOUNT_FRAME_ACCUM_CLEAR_EN
    clr[d]     = c;
`else
    if (c) clr[d] = 1'b0;
`endif
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  initial begin
    in_b[0] = '0;
    in_b[1] = '0;
    model_clear(0);
    model_clear(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", int'(in_rdy), 3);
    check("rst_out_val", int'(out_val), 0);
    check("rst_out", out_w[0], 0);
    rst = 2'b00;

    // 00,01,03,FF -> 11
    cyc(0, 1, 8'h00, 1, 0, 0);
    cyc(0, 1, 8'h01, 1, 0, 0);
    cyc(0, 1, 8'h03, 1, 0, 0);
    cyc(0, 1, 8'hFF, 1, 0, 0);
    check("f1_out_val", int'(out_val[0]), 1);
    check("f1_out", out_w[0], 11);
    cyc(0, 0, 8'h00, 1, 0, 0);
    check("f1_in_rdy_after", int'(in_rdy[0]), 1);

    // FF x4 held with out_rdy low, offered byte ignored
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("hold_out", out_w[0], 32);
      check("hold_in_rdy", int'(in_rdy[0]), 0);
      cyc(0, 1, 8'h0F, 0, 0, 0);
    end
    check("hold_out_end", out_w[0], 32);
    cyc(0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h01, 0, 0, 0);
    check("after_hold_out", out_w[0], 4);
    cyc(0, 0, 8'h00, 1, 0, 0);

    // gapped frame 0F, idle, idle, F0, AA, 55 -> 16
    cyc(0, 1, 8'h0F, 0, 0, 0);
    cyc(0, 0, 8'hFF, 0, 0, 0);
    cyc(0, 0, 8'hFF, 0, 0, 0);
    cyc(0, 1, 8'hF0, 0, 0, 0);
    cyc(0, 1, 8'hAA, 0, 0, 0);
    cyc(0, 1, 8'h55, 0, 0, 0);
    check("gap_out", out_w[0], 16);
    cyc(0, 0, 8'h00, 1, 0, 0);

    // partial frame dropped by reset
    cyc(0, 1, 8'h81, 0, 0, 0);
    cyc(0, 1, 8'h7E, 0, 0, 0);
    cyc(0, 1, 8'hFF, 0, 1, 0);
    check("mid_rst_out", out_w[0], 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h01, 0, 0, 0);
    check("mid_rst_total", out_w[0], 4);
    cyc(0, 0, 8'h00, 0, 1, 0);
    check("done_rst_out_val", int'(out_val[0]), 0);

    // single-byte frames
    cyc(1, 1, 8'h80, 1, 0, 0);
    check("n1_out_a", out_w[1], 1);
    check("n1_in_rdy_a", int'(in_rdy[1]), 0);
    cyc(1, 1, 8'hFF, 1, 0, 0);
    check("n1_in_rdy_b", int'(in_rdy[1]), 1);
    cyc(1, 1, 8'hFF, 1, 0, 0);
    check("n1_out_b", out_w[1], 8);
    cyc(1, 0, 8'h00, 1, 0, 0);

`ifdef POPCOUNT_FRAME_ACCUM_CLEAR_EN
    cyc(0, 1, 8'hFF, 0, 0, 0);
    cyc(0, 1, 8'hFF, 0, 0, 0);
    cyc(0, 1, 8'hFF, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h01, 0, 0, 0);
    check("clear_total", out_w[0], 4);
    cyc(0, 0, 8'h00, 1, 0, 0);
`endif

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 400; i++) begin
        cyc(d, ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
            ($urandom % 60) == 0, ($urandom % 45) == 0);
      end
      compare(d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
